// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation read-side fetcher.
//   PIX_W / ADDR_W : default pixel and memory address widths
//   BLK_DEF        : default block side length (legal 2..16)
//   IMG_W_DEF      : default line stride in pixels
//   COORD_W        : width of the x/y tags carried with each pixel pair
//   me_state_e     : fetcher control states
package me_pkg;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned BLK_DEF   = 4;
    localparam int unsigned IMG_W_DEF = 32;
    localparam int unsigned COORD_W   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain
    } me_state_e;

endpackage

// File: rtl/me_skid_buf2.sv
// Two-entry FIFO holding returned pixel pairs until the SAD engine accepts them.
//   clock, reset_n : clock and synchronous active-low reset
//   push, push_data: write an entry (ignored when full and not popping)
//   pop            : remove the head entry (ignored when empty)
//   head           : current head entry, {tmpl, srch, x, y, last}
//   count          : number of valid entries (0..2)
module me_skid_buf2 #(
    parameter int unsigned W = 25
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] slot_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count_q != 2'd0);
    // A full buffer still accepts a write when the head leaves at the same edge.
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (do_push) begin
                slot_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head  = slot_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/me_block_fetcher.sv
// Read-side master for the dual-port pixel memory. On start it walks a BLK x BLK
// template block on port A and the co-located search block on port B (1-cycle
// synchronous read latency) and streams tagged pixel pairs over valid/ready.
//   clock, reset_n        : clock and synchronous active-low reset
//   start, tmpl_base,
//   srch_base             : block request, bases latched when accepted in idle
//   busy, done            : busy while a block is active, one-cycle done pulse
//   address_a/b, wren_a/b,
//   data_a/b, q_a/b       : memory ports (read-only use)
//   out_*                 : pixel pair stream with x/y tags and last flag
module me_block_fetcher
    import me_pkg::*;
#(
    parameter int unsigned AWIDTH = ADDR_W,
    parameter int unsigned DWIDTH = PIX_W,
    parameter int unsigned BLK    = BLK_DEF,
    parameter int unsigned IMG_W  = IMG_W_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [AWIDTH-1:0]  tmpl_base,
    input  logic [AWIDTH-1:0]  srch_base,
    output logic               busy,
    output logic               done,
    output logic [AWIDTH-1:0]  address_a,
    output logic [AWIDTH-1:0]  address_b,
    output logic               wren_a,
    output logic               wren_b,
    output logic [DWIDTH-1:0]  data_a,
    output logic [DWIDTH-1:0]  data_b,
    input  logic [DWIDTH-1:0]  q_a,
    input  logic [DWIDTH-1:0]  q_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DWIDTH-1:0]  out_tmpl,
    output logic [DWIDTH-1:0]  out_srch,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_last
);

    localparam int unsigned EW = 2 * DWIDTH + 2 * COORD_W + 1;
    localparam logic [COORD_W-1:0] LastC  = COORD_W'(BLK - 1);
    localparam logic [AWIDTH-1:0]  Stride = AWIDTH'(IMG_W);

    me_state_e           state_q;
    logic                busy_q, done_q;
    logic [AWIDTH-1:0]   addr_a_q, addr_b_q, row_a_q, row_b_q;
    // Tag of the read sitting on the address registers, and whether memory has yet to sample it.
    logic [COORD_W-1:0]  ax_q, ay_q;
    logic                a_pend_q;
    // Tag of the read whose data is on q_a/q_b and not yet in the buffer.
    logic [COORD_W-1:0]  qx_q, qy_q;
    logic                q_pend_q;

    logic                push, pop, issue, q_pend_d, x_wrap;
    logic [1:0]          count, cnt_after;
    logic [EW-1:0]       head, push_data;
    logic [COORD_W-1:0]  nx, ny;
    logic [AWIDTH-1:0]   nrow_a, nrow_b;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign push      = q_pend_q && ((count != 2'd2) || pop);
    // An unpushed return stays valid on q only while the address registers hold still.
    assign q_pend_d  = a_pend_q || (q_pend_q && !push);
    assign cnt_after = count + {1'b0, push} - {1'b0, pop};
    // Move the address only if whatever is on q after this edge is sure to fit next edge.
    assign issue     = (state_q == StFetch) && (!q_pend_d || (cnt_after != 2'd2));

    assign x_wrap = (ax_q == LastC);
    assign nx     = x_wrap ? '0 : ax_q + 1'b1;
    assign ny     = x_wrap ? ay_q + 1'b1 : ay_q;
    assign nrow_a = x_wrap ? row_a_q + Stride : row_a_q;
    assign nrow_b = x_wrap ? row_b_q + Stride : row_b_q;

    assign push_data = {q_a, q_b, qx_q, qy_q, (qx_q == LastC) && (qy_q == LastC)};

    me_skid_buf2 #(
        .W (EW)
    ) u_buf (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign {out_tmpl, out_srch, out_x, out_y, out_last} = head;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            row_a_q  <= '0;
            row_b_q  <= '0;
            ax_q     <= '0;
            ay_q     <= '0;
            a_pend_q <= 1'b0;
            qx_q     <= '0;
            qy_q     <= '0;
            q_pend_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            a_pend_q <= 1'b0;
            q_pend_q <= q_pend_d;
            if (a_pend_q) begin
                qx_q <= ax_q;
                qy_q <= ay_q;
            end
            case (state_q)
                StIdle: begin
                    // A start coinciding with the done pulse is not taken.
                    if (start && !done_q) begin
                        row_a_q  <= tmpl_base;
                        row_b_q  <= srch_base;
                        addr_a_q <= tmpl_base;
                        addr_b_q <= srch_base;
                        ax_q     <= '0;
                        ay_q     <= '0;
                        a_pend_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= StFetch;
                    end
                end
                StFetch: begin
                    if (issue) begin
                        row_a_q  <= nrow_a;
                        row_b_q  <= nrow_b;
                        addr_a_q <= nrow_a + AWIDTH'(nx);
                        addr_b_q <= nrow_b + AWIDTH'(nx);
                        ax_q     <= nx;
                        ay_q     <= ny;
                        a_pend_q <= 1'b1;
                        if ((nx == LastC) && (ny == LastC)) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if ((cnt_after == 2'd0) && !q_pend_d) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign address_a = addr_a_q;
    assign address_b = addr_b_q;
    assign wren_a    = 1'b0;
    assign wren_b    = 1'b0;
    assign data_a    = '0;
    assign data_b    = '0;

endmodule

// File: tb/tb_me_block_fetcher.sv
module tb_me_block_fetcher;

    localparam int BLK  = 4;
    localparam int IMGW = 32;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] tmpl_base = '0, srch_base = '0;
    logic       busy, done, wren_a, wren_b, out_valid, out_last;
    logic       out_ready = 1'b1;
    logic [9:0] address_a, address_b;
    logic [7:0] data_a, data_b, q_a, q_b, out_tmpl, out_srch;
    logic [3:0] out_x, out_y;

    me_block_fetcher dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .tmpl_base (tmpl_base),
        .srch_base (srch_base),
        .busy      (busy),
        .done      (done),
        .address_a (address_a),
        .address_b (address_b),
        .wren_a    (wren_a),
        .wren_b    (wren_b),
        .data_a    (data_a),
        .data_b    (data_b),
        .q_a       (q_a),
        .q_b       (q_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tmpl  (out_tmpl),
        .out_srch  (out_srch),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_last  (out_last)
    );

    always #5 clock = ~clock;

    // Dual-port memory model, 1-cycle synchronous read.
    logic [7:0] core [0:1023];
    always @(posedge clock) begin
        q_a <= core[address_a];
        q_b <= core[address_b];
    end

    typedef struct packed {
        logic [7:0] t;
        logic [7:0] s;
        logic [3:0] x;
        logic [3:0] y;
        logic       l;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0, n_pass = 0;
    int   done_cnt = 0, exp_done = 0, acc_cnt = 0;
    bit   rand_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic logic [9:0] pix_addr(input logic [9:0] base, input int x, input int y);
        return base + 10'(y * IMGW + x);
    endfunction

    // Reference: raster walk of the block, pixels read straight from the memory image.
    function automatic void push_block(input logic [9:0] tb_, input logic [9:0] sb_);
        exp_t e;
        for (int y = 0; y < BLK; y++) begin
            for (int x = 0; x < BLK; x++) begin
                e.t = core[pix_addr(tb_, x, y)];
                e.s = core[pix_addr(sb_, x, y)];
                e.x = 4'(x);
                e.y = 4'(y);
                e.l = (x == BLK - 1) && (y == BLK - 1);
                exp_q.push_back(e);
            end
        end
    endfunction

    // Ready driver.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every transfer, checks stall stability and done.
    logic [24:0] mon_bus, prev_bus = '0;
    bit          prev_stall = 1'b0;
    exp_t        mon_e;
    always @(negedge clock) begin
        mon_bus = {out_tmpl, out_srch, out_x, out_y, out_last};
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {6'd0, out_valid, mon_bus}, {6'd0, 1'b1, prev_bus});
            if (out_valid && out_ready) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pair: got %0h expected no pair", mon_bus);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pair", {7'd0, mon_bus}, {7'd0, mon_e});
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_all_accepted", exp_q.size(), 0);
                chk("done_busy_low", {31'd0, busy}, 0);
            end
            prev_stall = out_valid && !out_ready;
            prev_bus   = mon_bus;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, {4'd0, busy, done, out_valid, out_last, out_x, out_y, out_tmpl, out_srch}, 0);
        chk({tag, "_addr"}, {12'd0, address_a, address_b}, 0);
    endtask

    // Runs one block. timing: ready held high, exact latency/address checks.
    // poke: extra start while busy. pre_ignored: start raised during the done cycle.
    task automatic run_block(input logic [9:0] tb_, input logic [9:0] sb_, input bit timing,
                             input bit poke, input bit pre_ignored);
        bit seen;
        if (!pre_ignored) begin
            @(posedge clock);
            #1;
        end
        start     = 1'b1;
        tmpl_base = tb_;
        srch_base = sb_;
        if (pre_ignored) begin
            @(posedge clock);
            #1;
            chk("start_in_done_ignored", {31'd0, busy}, 0);
        end
        @(posedge clock);
        push_block(tb_, sb_);
        exp_done++;
        #1;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 1);
        chk("addr_a_start", address_a, tb_);
        chk("addr_b_start", address_b, sb_);
        seen = 1'b0;
        for (int e = 1; e <= 300 && !seen; e++) begin
            @(posedge clock);
            #1;
            if (poke && e == 4) begin
                start     = 1'b1;
                tmpl_base = ~tb_;
                srch_base = ~sb_;
            end
            if (poke && e == 5) start = 1'b0;
            if (timing && e < BLK * BLK) begin
                chk("addr_a_walk", address_a, pix_addr(tb_, e % BLK, e / BLK));
                chk("addr_b_walk", address_b, pix_addr(sb_, e % BLK, e / BLK));
            end
            if (timing && e == 1) chk("valid_e1", {31'd0, out_valid}, 0);
            if (timing && e == 2) chk("valid_e2", {31'd0, out_valid}, 1);
            if (done) begin
                seen = 1'b1;
                if (timing) chk("done_edge", e, BLK * BLK + 2);
            end
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL done_timeout: got no done expected done within 300 cycles");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        int acc0;
        for (int i = 0; i < 1024; i++) core[i] = 8'(i);
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Basic stream: pairs (i, i+64).
        run_block(10'd0, 10'd64, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 1024; i++) core[i] = 8'($urandom);

        // Search block crossing the top of the address space.
        run_block(10'd300, 10'd1020, 1'b1, 1'b0, 1'b0);

        // Start while busy is ignored.
        run_block(10'd77, 10'd900, 1'b1, 1'b1, 1'b0);

        // Back-to-back: start raised in the done cycle, taken one cycle later.
        run_block(10'd513, 10'd5, 1'b1, 1'b0, 1'b1);

        // Backpressure with random bases.
        rand_ready = 1'b1;
        for (int b = 0; b < 4; b++) run_block(10'($urandom), 10'($urandom), 1'b0, 1'b0, 1'b0);
        rand_ready = 1'b0;

        // Reset after the 6th accept abandons the block.
        @(posedge clock);
        #1;
        start     = 1'b1;
        tmpl_base = 10'd200;
        srch_base = 10'd40;
        @(posedge clock);
        push_block(10'd200, 10'd40);
        #1;
        start = 1'b0;
        acc0  = acc_cnt;
        hit   = 1'b0;
        for (int c = 0; c < 60 && !hit; c++) begin
            @(posedge clock);
            #1;
            if (acc_cnt - acc0 >= 6) hit = 1'b1;
        end
        if (!hit) begin
            n_checks++;
            $display("FAIL six_accepts: got %0d accepts expected 6", acc_cnt - acc0);
        end
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        exp_q.delete();
        check_reset_outputs("midop_reset");
        reset_n = 1'b1;
        chk("no_done_on_abort", done_cnt, exp_done);
        run_block(10'd100, 10'd700, 1'b1, 1'b0, 1'b0);

        repeat (3) @(posedge clock);
        #1;
        chk("done_count", done_cnt, exp_done);
        chk("queue_empty_end", exp_q.size(), 0);
        chk("write_ports_tied", {14'd0, wren_a, wren_b, data_a, data_b}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/me_block_fetcher.md
Name: me_block_fetcher

Overview:
- Read-side master for the dual-port pixel memory of the motion estimation datapath.
- On start, walks a BLK x BLK template block through port A and the co-located search block through port B. Both ports use 1-cycle synchronous read latency.
- Streams pixel pairs to the SAD engine over a valid/ready interface.
- Holds a 2-entry skid buffer so backpressure never loses data in flight. Never writes the memory.

Parameters:
- AWIDTH, 10, memory address width; all address arithmetic is modulo 2**AWIDTH.
- DWIDTH, 8, pixel width; matches the memory q_a/q_b width.
- BLK, 4, block side length in pixels; legal range 2..16.
- IMG_W, 32, line stride in pixels between vertically adjacent pixels.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- tmpl_base  in  AWIDTH  template block top-left address; latched at start.
- srch_base  in  AWIDTH  search block top-left address; latched at start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last pair is accepted.
- address_a  out  AWIDTH  registered template read address.
- address_b  out  AWIDTH  registered search read address.
- wren_a  out  1  tied 0.
- wren_b  out  1  tied 0.
- data_a  out  DWIDTH  tied 0.
- data_b  out  DWIDTH  tied 0.
- q_a  in  DWIDTH  port A read data, valid one edge after the address.
- q_b  in  DWIDTH  port B read data, valid one edge after the address.
- out_valid  out  1  pixel pair available.
- out_ready  in  1  consumer accepts; a transfer occurs when valid and ready are both high at an edge.
- out_tmpl  out  DWIDTH  template pixel.
- out_srch  out  DWIDTH  search pixel.
- out_x  out  4  column index of the pair.
- out_y  out  4  row index of the pair.
- out_last  out  1  high with pair (BLK-1, BLK-1).

Behaviour:
- Reset (reset_n low at an edge) applies in any state:
  - state IDLE; busy, done, out_valid, out_last = 0.
  - address_a, address_b, out_x, out_y, out_tmpl, out_srch = 0.
  - buffer and in-flight flag cleared.
  - Reset mid-block abandons the block with no done pulse.
- IDLE:
  - start=1 at edge E0 latches both bases.
  - address_a=tmpl_base and address_b=srch_base after E0; busy=1; go to FETCH.
- FETCH:
  - Issue a read (advance x,y) only when buffered entries + in-flight reads < 2. Returns held in flight are not re-read.
  - Address = row pointer + x. Row pointer += IMG_W when x wraps BLK-1 -> 0.
  - After issuing (BLK-1, BLK-1), go to DRAIN.
- Returned data: each read returns one edge later; q_a/q_b plus its x,y tag are written into the buffer at the following edge.
- Output order and latency:
  - Output is head-of-buffer, raster order, no gaps when out_ready stays high.
  - First out_valid rises at E2; sustained rate is 1 pair/cycle.
- DRAIN: stay until the buffer is empty and nothing is in flight, then go to IDLE. At that transition, done=1 for one cycle and busy=0 at the same edge.
- Backpressure:
  - out_ready low holds out_valid and all out_* stable.
  - Issuing stops once 2 entries are committed.
  - No data loss or duplication.
- Simultaneous events:
  - A buffer write and a pop at the same edge are both performed.
  - start while busy is ignored.
  - start in the same cycle as done is ignored; it is accepted one cycle later.
- Address wrap past 2**AWIDTH-1 wraps to 0 silently.

Decomposition:
- Shared package me_pkg: PIX_W, ADDR_W, the BLK and IMG_W defaults, the state enum (IDLE, FETCH, DRAIN).
- Sub-module me_skid_buf2: 2-entry FIFO carrying {tmpl, srch, x, y, last}, with push/pop/count outputs.
- The address generator and credit logic stay in the top.

Test Plan:
- Basic stream:
  - Stimulus: memory preloaded with core[i]=i[7:0]; tmpl_base=0, srch_base=64, BLK=4, IMG_W=32, out_ready=1.
  - Response: 16 pairs; the first is (0,64) with out_valid at E2. The pair at x=3,y=1 is (35,99). out_last with (99,163). done after the 16th accept; no gaps.
- Backpressure:
  - Stimulus: same block, out_ready toggles 1,0,0,1,… randomly.
  - Response: identical 16-pair sequence; outputs stable while stalled; never more than 2 reads outstanding.
- Wrap:
  - Stimulus: srch_base=1020.
  - Response: row 0 search addresses are 1020,1021,1022,1023; row 1 is 28,29,30,31 (mod 1024).
- Busy start: a second start pulse at E5 is ignored; exactly one done pulse occurs and the pair count stays 16.
- Reset mid-op:
  - Stimulus: reset_n low for 1 cycle after the 6th accept, then start with tmpl_base=100.
  - Response: all outputs 0 after reset; no done pulse for the aborted block; the new stream starts at core[100].
- Back-to-back: start one cycle after done is accepted; out_valid rises 2 edges later with the new base data.
